psram_responder: RTL and testbench

- Device-side responder for the asynchronous CellularRAM bus (MemAdr, MemDB, RamAdv, RamCS, MemOE, MemWR, RamLB, RamUB).
- Services reads and writes from an internal word array with programmable access latency.
- Lets the synthesizer's RAM controller be exercised on-chip and in simulation without the external device.
- Sits on the far end of the same pins the controller drives; shares the controller's clock.

---
 rtl/psram_responder_pkg.sv | 29 ++
 rtl/psram_resp_array.sv | 48 ++++
 rtl/psram_responder.sv | 171 +++++++++++++++++
 tb/tb_psram_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_responder_pkg.sv
// Shared constants for the CellularRAM bus responder: FSM state codes,
// registered control bundle and bus widths.
package psram_responder_pkg;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned FULL_ADDR_W = 23;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RD_WAIT  = 2'd1;
    localparam logic [1:0] ST_RD_DRIVE = 2'd2;
    localparam logic [1:0] ST_WR_WAIT  = 2'd3;

    // All bus controls are active low; this bundle holds their registered copies.
    typedef struct packed {
        logic adv;
        logic cs;
        logic oe;
        logic we;
        logic lb;
        logic ub;
    } ctrl_t;

    localparam ctrl_t BUS_IDLE_CTRL = '{adv: 1'b1, cs: 1'b1, oe: 1'b1, we: 1'b1, lb: 1'b1, ub: 1'b1};

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/psram_resp_array.sv
// Word array for the responder: byte-masked write port, combinational bus
// read port and a registered backdoor read port (returns old data on collision).
module psram_resp_array
    import psram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W   = 3,
    parameter logic [15:0] INIT_VAL = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [1:0]        i_wr_be,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic [DATA_W-1:0] o_dbg_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dbg_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= INIT_VAL;
            end
        end else if (i_wr_en) begin
            if (i_wr_be[0]) r_mem[i_wr_addr][7:0]  <= i_wr_data[7:0];
            if (i_wr_be[1]) r_mem[i_wr_addr][15:8] <= i_wr_data[15:8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dbg_data <= '0;
        end else begin
            r_dbg_data <= r_mem[i_dbg_addr];
        end
    end

    assign o_rd_data  = r_mem[i_rd_addr];
    assign o_dbg_data = r_dbg_data;

endmodule

// File: rtl/psram_responder.sv
// Asynchronous-mode CellularRAM device model servicing reads/writes from an
// internal array. Define PSRAM_RESP_STATS_EN to enable the statistics counters.
module psram_responder
    import psram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned READ_LAT  = 3,
    parameter int unsigned WRITE_MIN = 3,
    parameter logic [15:0] INIT_VAL  = 16'h0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [FULL_ADDR_W-1:0] MemAdr,
    inout  wire  [DATA_W-1:0]      MemDB,
    input  logic                   RamAdv,
    input  logic                   RamClk,
    input  logic                   RamCS,
    input  logic                   MemOE,
    input  logic                   MemWR,
    input  logic                   RamLB,
    input  logic                   RamUB,
    input  logic [ADDR_W-1:0]      dbg_addr,
    output logic [DATA_W-1:0]      dbg_data,
    output logic                   busy,
    output logic                   err,
    output logic [15:0]            rd_count,
    output logic [15:0]            wr_count,
    output logic [15:0]            abort_count
);

    ctrl_t               r_ctl;
    logic [ADDR_W-1:0]   r_adr_in;
    logic [DATA_W-1:0]   r_db;

    logic [1:0]          r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [2:0]          r_cnt;
    logic [DATA_W-1:0]   r_wdata;
    logic [1:0]          r_wbe;
    logic                r_err;

    logic                w_wr_exit;
    logic                w_wr_ok;
    logic                w_wr_commit;
    logic                w_wr_short;
    logic                w_rd_abort;
    logic                w_rd_done;
    logic [DATA_W-1:0]   w_rd_data;
    logic                w_drv_lo;
    logic                w_drv_hi;
    logic                w_unused;

    assign w_unused = &{1'b0, RamClk, MemAdr[FULL_ADDR_W-1:ADDR_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctl    <= BUS_IDLE_CTRL;
            r_adr_in <= '0;
            r_db     <= '0;
        end else begin
            r_ctl    <= '{adv: RamAdv, cs: RamCS, oe: MemOE, we: MemWR, lb: RamLB, ub: RamUB};
            r_adr_in <= MemAdr[ADDR_W-1:0];
            r_db     <= MemDB;
        end
    end

    assign w_wr_exit   = (r_state == ST_WR_WAIT) && (r_ctl.we || r_ctl.cs);
    assign w_wr_ok     = (r_cnt >= 3'(WRITE_MIN));
    assign w_wr_commit = w_wr_exit && w_wr_ok;
    assign w_wr_short  = w_wr_exit && !w_wr_ok;
    assign w_rd_abort  = (r_state == ST_RD_WAIT) && (r_ctl.cs || r_ctl.oe);
    assign w_rd_done   = (r_state == ST_RD_DRIVE) && (r_ctl.cs || r_ctl.oe);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_wdata <= '0;
            r_wbe   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_wr_short;
            case (r_state)
                ST_IDLE: begin
                    // WE wins over OE when both are low at access start.
                    if (!r_ctl.cs && (!r_ctl.we || !r_ctl.oe)) begin
                        r_state <= !r_ctl.we ? ST_WR_WAIT : ST_RD_WAIT;
                        r_cnt   <= '0;
                        if (!r_ctl.adv) r_addr <= r_adr_in;
                    end
                end
                ST_RD_WAIT: begin
                    if (w_rd_abort) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == 3'(READ_LAT - 1)) begin
                        r_state <= ST_RD_DRIVE;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                ST_RD_DRIVE: begin
                    if (w_rd_done) r_state <= ST_IDLE;
                end
                ST_WR_WAIT: begin
                    if (w_wr_exit) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_wdata <= r_db;
                        r_wbe   <= {~r_ctl.ub, ~r_ctl.lb};
                        if (r_cnt != 3'd7) r_cnt <= r_cnt + 3'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    psram_resp_array #(
        .ADDR_W   (ADDR_W),
        .INIT_VAL (INIT_VAL)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (w_wr_commit),
        .i_wr_addr  (r_addr),
        .i_wr_data  (r_wdata),
        .i_wr_be    (r_wbe),
        .i_rd_addr  (r_addr),
        .o_rd_data  (w_rd_data),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

    // Byte lanes follow the registered enables every cycle while driving.
    assign w_drv_lo = (r_state == ST_RD_DRIVE) && !r_ctl.lb;
    assign w_drv_hi = (r_state == ST_RD_DRIVE) && !r_ctl.ub;

    assign MemDB[7:0]  = w_drv_lo ? w_rd_data[7:0]  : 8'bz;
    assign MemDB[15:8] = w_drv_hi ? w_rd_data[15:8] : 8'bz;

    assign busy = (r_state != ST_IDLE);
    assign err  = r_err;

`ifdef PSRAM_RESP_STATS_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;
    logic [15:0] r_abort_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_count    <= '0;
            r_wr_count    <= '0;
            r_abort_count <= '0;
        end else begin
            if (w_rd_done)                r_rd_count    <= sat_inc16(r_rd_count);
            if (w_wr_commit)              r_wr_count    <= sat_inc16(r_wr_count);
            if (w_rd_abort || w_wr_short) r_abort_count <= sat_inc16(r_abort_count);
        end
    end

    assign rd_count    = r_rd_count;
    assign wr_count    = r_wr_count;
    assign abort_count = r_abort_count;
`else
    assign rd_count    = '0;
    assign wr_count    = '0;
    assign abort_count = '0;
`endif

endmodule

// File: tb/tb_psram_responder.sv
// Self-checking bench for psram_responder: directed vector table, a few
// hand sequences (reset, mid-read reset) and randomized traffic vs. a word model.
module tb_psram_responder;

    localparam int unsigned AW   = 3;
    localparam int unsigned RL   = 3;
    localparam int unsigned WM   = 3;
    localparam logic [15:0] INIT = 16'hA5A5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [22:0] MemAdr;
    wire  [15:0] MemDB;
    logic        RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB;
    logic [AW-1:0] dbg_addr;
    logic [15:0] dbg_data;
    logic        busy, err;
    logic [15:0] rd_count, wr_count, abort_count;

    logic [15:0] tb_dq;
    logic        tb_oe_lo, tb_oe_hi;

    assign MemDB[7:0]  = tb_oe_lo ? tb_dq[7:0]  : 8'bz;
    assign MemDB[15:8] = tb_oe_hi ? tb_dq[15:8] : 8'bz;

    always #5 clk = ~clk;

    psram_responder #(
        .ADDR_W    (AW),
        .READ_LAT  (RL),
        .WRITE_MIN (WM),
        .INIT_VAL  (INIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MemAdr      (MemAdr),
        .MemDB       (MemDB),
        .RamAdv      (RamAdv),
        .RamClk      (RamClk),
        .RamCS       (RamCS),
        .MemOE       (MemOE),
        .MemWR       (MemWR),
        .RamLB       (RamLB),
        .RamUB       (RamUB),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .busy        (busy),
        .err         (err),
        .rd_count    (rd_count),
        .wr_count    (wr_count),
        .abort_count (abort_count)
    );

    int unsigned n_checks = 0;
    int unsigned n_errs   = 0;

    // Reference model: array contents, last latched address, event tallies.
    logic [15:0] m_mem [8];
    logic [2:0]  m_last;
    logic [15:0] m_rd, m_wr, m_ab;

    typedef struct {
        bit          is_wr;
        logic [2:0]  a;
        logic [15:0] d;
        bit          lbn, ubn, advn, oen;
        int          k;
        bit          exp_flag;  // write: err pulse expected; read: abort expected
        logic [15:0] exp_val;   // write: word afterwards; read: bus while driven
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        RamCS = 1'b1; MemWR = 1'b1; MemOE = 1'b1; RamAdv = 1'b1;
        RamLB = 1'b1; RamUB = 1'b1;
        tb_dq = 16'h0000; tb_oe_lo = 1'b1; tb_oe_hi = 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = INIT;
        m_last = 3'd0;
        m_rd = 16'd0; m_wr = 16'd0; m_ab = 16'd0;
    endtask

    task automatic check_stats(input string tag);
`ifdef PSRAM_RESP_STATS_EN
        check({tag, "_rd_count"},    rd_count,    m_rd);
        check({tag, "_wr_count"},    wr_count,    m_wr);
        check({tag, "_abort_count"}, abort_count, m_ab);
`else
        check({tag, "_stats_tied"},  rd_count | wr_count | abort_count, 16'h0000);
`endif
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                          input bit lbn, input bit ubn);
        return {ubn ? old[15:8] : d[15:8], lbn ? old[7:0] : d[7:0]};
    endfunction

    task automatic do_write(input logic [2:0] a, input logic [15:0] d, input bit lbn,
                            input bit ubn, input bit advn, input bit oen, input int k,
                            input bit exp_err, input logic [15:0] exp_word);
        logic [2:0]  eff;
        logic [15:0] old;
        int          errs;
        eff = advn ? m_last : a;
        old = m_mem[eff];
        dbg_addr = eff;
        MemAdr = {20'($urandom), a};
        RamAdv = advn; RamCS = 1'b0; MemWR = 1'b0; MemOE = oen;
        RamLB = lbn; RamUB = ubn;
        tb_dq = d; tb_oe_lo = 1'b1; tb_oe_hi = 1'b1;
        repeat (k) tick();
        bus_idle();
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (err) errs++;
            if (i == 1) check("wr_dbg_old_same_cycle", dbg_data, old);
        end
        check("wr_err_pulses", 16'(errs), exp_err ? 16'd1 : 16'd0);
        check("wr_word", dbg_data, exp_word);
        check("wr_busy_idle", {15'd0, busy}, 16'd0);
        m_last = eff;
        if (k - 1 >= int'(WM)) begin
            m_mem[eff] = merge(old, d, lbn, ubn);
            m_wr++;
        end else begin
            m_ab++;
        end
        check_stats("wr");
    endtask

    task automatic do_read(input logic [2:0] a, input bit lbn, input bit ubn, input bit advn,
                           input int k, input bit exp_abort, input logic [15:0] exp_bus);
        logic [2:0] eff;
        eff = advn ? m_last : a;
        MemAdr = {20'($urandom), a};
        RamAdv = advn; RamCS = 1'b0; MemOE = 1'b0; MemWR = 1'b1;
        RamLB = lbn; RamUB = ubn;
        tb_dq = 16'h0000;
        tb_oe_lo = exp_abort ? 1'b1 : lbn;
        tb_oe_hi = exp_abort ? 1'b1 : ubn;
        for (int j = 1; j <= k; j++) begin
            tick();
            if (j == 2) check("rd_busy", {15'd0, busy}, 16'd1);
            if (exp_abort)                check("rd_abort_undriven", MemDB, 16'h0000);
            else if (j >= int'(RL) + 2)   check("rd_bus", MemDB, exp_bus);
        end
        RamCS = 1'b1; MemOE = 1'b1;
        tick();
        if (exp_abort) check("rd_abort_undriven", MemDB, 16'h0000);
        else           check("rd_bus_tail", MemDB, exp_bus);
        tick();
        bus_idle();
        #1;
        check("rd_released", MemDB, 16'h0000);
        check("rd_busy_idle", {15'd0, busy}, 16'd0);
        tick();
        m_last = eff;
        if (k > int'(RL)) m_rd++;
        else              m_ab++;
        check_stats("rd");
    endtask

    initial begin
        vecs[0]  = '{1'b1, 3'd3, 16'h1234, 0, 0, 0, 1, 6, 0, 16'h1234};
        vecs[1]  = '{1'b0, 3'd3, 16'h0000, 0, 0, 0, 1, 5, 0, 16'h1234};
        vecs[2]  = '{1'b1, 3'd3, 16'hBEEF, 0, 1, 0, 1, 6, 0, 16'h12EF};
        vecs[3]  = '{1'b0, 3'd3, 16'h0000, 1, 0, 0, 1, 4, 0, 16'h1200};
        vecs[4]  = '{1'b1, 3'd3, 16'h5555, 0, 0, 0, 1, 2, 1, 16'h12EF};
        vecs[5]  = '{1'b0, 3'd3, 16'h0000, 0, 0, 0, 1, 1, 1, 16'h0000};
        vecs[6]  = '{1'b1, 3'd6, 16'h0F0F, 0, 0, 1, 1, 4, 0, 16'h0F0F};
        vecs[7]  = '{1'b1, 3'd2, 16'h7777, 0, 0, 0, 1, 3, 1, 16'hA5A5};
        vecs[8]  = '{1'b0, 3'd5, 16'h0000, 0, 0, 0, 1, 4, 0, 16'hA5A5};
        vecs[9]  = '{1'b0, 3'd5, 16'h0000, 0, 0, 0, 1, 3, 1, 16'h0000};
        vecs[10] = '{1'b1, 3'd1, 16'hC3C3, 0, 0, 0, 0, 5, 0, 16'hC3C3};
        vecs[11] = '{1'b0, 3'd7, 16'h0000, 0, 0, 1, 1, 6, 0, 16'hC3C3};

        RamClk = 1'b0;
        MemAdr = '0;
        dbg_addr = 3'd5;
        bus_idle();
        rst_n = 1'b0;
        model_reset();
        tick(); tick();
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_err", {15'd0, err}, 16'd0);
        check("rst_dbg", dbg_data, 16'h0000);
        check("rst_bus_undriven", MemDB, 16'h0000);
        check_stats("rst");
        rst_n = 1'b1;
        tick();
        check("rst_dbg_init", dbg_data, INIT);

        foreach (vecs[i]) begin
            if (vecs[i].is_wr)
                do_write(vecs[i].a, vecs[i].d, vecs[i].lbn, vecs[i].ubn, vecs[i].advn,
                         vecs[i].oen, vecs[i].k, vecs[i].exp_flag, vecs[i].exp_val);
            else
                do_read(vecs[i].a, vecs[i].lbn, vecs[i].ubn, vecs[i].advn,
                        vecs[i].k, vecs[i].exp_flag, vecs[i].exp_val);
        end

        for (int n = 0; n < 40; n++) begin
            logic [2:0]  a, eff;
            logic [15:0] d, word;
            bit          lbn, ubn, advn;
            int          k;
            a    = 3'($urandom_range(7, 0));
            d    = 16'($urandom);
            lbn  = 1'($urandom_range(1, 0));
            ubn  = 1'($urandom_range(1, 0));
            advn = ($urandom_range(3, 0) == 0);
            k    = int'($urandom_range(6, 1));
            eff  = advn ? m_last : a;
            if ($urandom_range(1, 0) == 1) begin
                word = (k - 1 >= int'(WM)) ? merge(m_mem[eff], d, lbn, ubn) : m_mem[eff];
                do_write(a, d, lbn, ubn, advn, 1'($urandom_range(1, 0)), k,
                         !(k - 1 >= int'(WM)), word);
            end else begin
                word = {ubn ? 8'h00 : m_mem[eff][15:8], lbn ? 8'h00 : m_mem[eff][7:0]};
                do_read(a, lbn, ubn, advn, k, !(k > int'(RL)), word);
            end
        end

        // Reset while the bus is being driven.
        MemAdr = {20'd0, 3'd3};
        RamAdv = 1'b0; RamCS = 1'b0; MemOE = 1'b0; MemWR = 1'b1;
        RamLB = 1'b0; RamUB = 1'b0;
        tb_oe_lo = 1'b0; tb_oe_hi = 1'b0;
        repeat (RL + 2) tick();
        check("mid_rd_driven", MemDB, m_mem[3]);
        rst_n = 1'b0;
        tb_dq = 16'h0000; tb_oe_lo = 1'b1; tb_oe_hi = 1'b1;
        #1;
        check("mid_rd_released", MemDB, 16'h0000);
        check("mid_rd_busy", {15'd0, busy}, 16'd0);
        check("mid_rd_dbg", dbg_data, 16'h0000);
        bus_idle();
        model_reset();
        check_stats("mid_rd");
        tick(); tick();
        rst_n = 1'b1;
        dbg_addr = 3'd3;
        tick();
        check("post_rst_mem3", dbg_data, INIT);
        dbg_addr = 3'd5;
        tick();
        check("post_rst_mem5", dbg_data, INIT);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
